// File: rtl/mux4_arbiter_pkg.sv
// rtl/mux4_arbiter_pkg.sv - shared state encodings and requester count for mux4_arbiter
package mux4_arbiter_pkg;

  localparam int NREQ = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mux4.sv
// rtl/mux4.sv - 4:1 one-bit mux datapath
module mux4 (
  input  logic       din_0,
  input  logic       din_1,
  input  logic       din_2,
  input  logic       din_3,
  input  logic [1:0] sel,
  output logic       mux_out
);

  always_comb begin
    mux_out = din_0;
    case (sel)
      2'd0: mux_out = din_0;
      2'd1: mux_out = din_1;
      2'd2: mux_out = din_2;
      2'd3: mux_out = din_3;
      default: mux_out = din_0;
    endcase
  end

endmodule

// File: rtl/mux4_arbiter.sv
// rtl/mux4_arbiter.sv - round-robin arbiter with hold limit driving the mux4 select
module mux4_arbiter
  import mux4_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] din,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      sel,
  output logic            dout,
  output logic            valid
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam bit         HOLD_EN  = (MAX_HOLD != 0);

  state_t          state, state_n;
  logic [1:0]      ptr, ptr_n;
  logic [1:0]      owner, owner_n;
  logic [7:0]      hold_cnt, hold_cnt_n;
  logic [NREQ-1:0] gnt_n;
  logic [1:0]      sel_n;
  logic [NREQ-1:0] owner_mask;
  logic            others_wait;
  logic [1:0]      winner;
  logic            mux_out;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] r, input logic [1:0] p);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [1:0]        idx;
    dbl = {r, r} >> p;
    rot = dbl[NREQ-1:0];
    idx = 2'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = 2'(i);
    end
    return idx + p;
  endfunction

  assign winner      = rr_pick(req, ptr);
  assign owner_mask  = 4'b0001 << owner;
  assign others_wait = |(req & ~owner_mask);

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    owner_n    = owner;
    hold_cnt_n = hold_cnt;
    gnt_n      = gnt;
    sel_n      = sel;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          gnt_n      = 4'b0001 << winner;
          owner_n    = winner;
          sel_n      = winner;
          hold_cnt_n = 8'd1;
          state_n    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!req[owner] || (HOLD_EN && (hold_cnt >= HOLD_LIM) && others_wait)) begin
          // Moving ptr past the owner puts a still-requesting owner last in line.
          gnt_n      = '0;
          ptr_n      = owner + 2'd1;
          hold_cnt_n = 8'd0;
          state_n    = ST_IDLE;
        end else if (hold_cnt != 8'hFF) begin
          hold_cnt_n = hold_cnt + 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ptr      <= 2'd0;
      owner    <= 2'd0;
      hold_cnt <= 8'd0;
      gnt      <= '0;
      sel      <= 2'd0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      hold_cnt <= hold_cnt_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
    end
  end

  mux4 u_mux4 (
    .din_0   (din[0]),
    .din_1   (din[1]),
    .din_2   (din[2]),
    .din_3   (din[3]),
    .sel     (sel),
    .mux_out (mux_out)
  );

  assign valid = |gnt;
  assign dout  = mux_out & valid;

endmodule
